// File: rtl/vga_text_console.sv
// vga_text_console
//   Character-stream front end for the vga_text video RAM port. Takes bytes
//   over a valid/ready handshake, keeps a cursor, interprets CR/LF/BS/FF,
//   auto-wraps at end of line and hardware-scrolls by copying video RAM.
//
// Ports
//   vclk        video/system clock (same clock as vga_text)
//   rst_n       synchronous reset, active low
//   char_in     input byte; char_valid qualifies it, char_ready accepts it
//   cls         clear-screen pulse, honoured in IDLE only
//   ram_addr    video RAM address   (registered)
//   ram_wdata   video RAM write data (registered)
//   ram_we      video RAM write enable (registered)
//   ram_rdata   video RAM read data for the address on ram_addr
//   cur_col     cursor column (registered)
//   cur_row     cursor row    (registered)
//   busy        high whenever the block is not in IDLE (registered)
module vga_text_console #(
  parameter int         COLS = 80,
  parameter int         ROWS = 30,
  parameter int         AW   = 12,
  parameter logic [7:0] FILL = 8'h20
) (
  input  logic                      vclk,
  input  logic                      rst_n,
  input  logic [7:0]                char_in,
  input  logic                      char_valid,
  output logic                      char_ready,
  input  logic                      cls,
  output logic [AW-1:0]             ram_addr,
  output logic [7:0]                ram_wdata,
  output logic                      ram_we,
  input  logic [7:0]                ram_rdata,
  output logic [$clog2(COLS)-1:0]   cur_col,
  output logic [$clog2(ROWS)-1:0]   cur_row,
  output logic                      busy
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  // Last cell of the screen and first cell of the bottom row.
  localparam logic [AW-1:0] LAST_CELL  = AW'(COLS*ROWS - 1);
  localparam logic [AW-1:0] LAST_COPY  = AW'(COLS*(ROWS-1) - 1);
  localparam logic [AW-1:0] BOTTOM_ROW = AW'(COLS*(ROWS-1));
  localparam logic [AW-1:0] ROW_STRIDE = AW'(COLS);
  localparam logic [CW-1:0] LAST_COL   = CW'(COLS - 1);
  localparam logic [RW-1:0] LAST_ROW   = RW'(ROWS - 1);

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    EXEC,
    SCROLL_RD,
    SCROLL_WR,
    SCROLL_FILL
  } state_t;

  state_t          state, state_d;
  logic [AW-1:0]   cnt, cnt_d;
  logic [CW-1:0]   col_d;
  logic [RW-1:0]   row_d;
  logic [AW-1:0]   row_base, row_base_d;
  logic [7:0]      byte_q, byte_d;
  logic [AW-1:0]   addr_d;
  logic [7:0]      wdata_d;
  logic            we_d;
  logic            adv_row;

  assign char_ready = (state == IDLE) & ~cls;

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    col_d      = cur_col;
    row_d      = cur_row;
    row_base_d = row_base;
    byte_d     = byte_q;
    addr_d     = ram_addr;
    wdata_d    = ram_wdata;
    we_d       = 1'b0;
    adv_row    = 1'b0;

    case (state)
      CLEAR: begin
        we_d    = 1'b1;
        addr_d  = cnt;
        wdata_d = FILL;
        if (cnt == LAST_CELL) begin
          cnt_d      = '0;
          col_d      = '0;
          row_d      = '0;
          row_base_d = '0;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      IDLE: begin
        // cls wins over a simultaneous byte; char_ready is already low.
        if (cls) begin
          cnt_d   = '0;
          state_d = CLEAR;
        end else if (char_valid) begin
          byte_d  = char_in;
          state_d = EXEC;
        end
      end

      EXEC: begin
        state_d = IDLE;
        if (byte_q >= 8'h20) begin
          we_d    = 1'b1;
          addr_d  = row_base + AW'(cur_col);
          wdata_d = byte_q;
          if (cur_col == LAST_COL) begin
            col_d   = '0;
            adv_row = 1'b1;
          end else begin
            col_d = cur_col + 1'b1;
          end
        end else begin
          case (byte_q)
            8'h0D: col_d = '0;
            8'h0A: begin
              col_d   = '0;
              adv_row = 1'b1;
            end
            8'h08: if (cur_col != '0) col_d = cur_col - 1'b1;
            8'h0C: begin
              cnt_d   = '0;
              state_d = CLEAR;
            end
            default: ;
          endcase
        end
        // Moving past the bottom row keeps the cursor on it and scrolls.
        if (adv_row) begin
          if (cur_row == LAST_ROW) begin
            cnt_d   = '0;
            state_d = SCROLL_RD;
          end else begin
            row_d      = cur_row + 1'b1;
            row_base_d = row_base + ROW_STRIDE;
          end
        end
      end

      // Copy cell cnt+COLS down to cnt. The source address sits on ram_addr
      // for one cycle; its data is on ram_rdata by the following edge, where
      // SCROLL_WR captures it into the write.
      SCROLL_RD: begin
        addr_d  = cnt + ROW_STRIDE;
        state_d = SCROLL_WR;
      end

      SCROLL_WR: begin
        we_d    = 1'b1;
        addr_d  = cnt;
        wdata_d = ram_rdata;
        if (cnt == LAST_COPY) begin
          cnt_d   = BOTTOM_ROW;
          state_d = SCROLL_FILL;
        end else begin
          cnt_d   = cnt + 1'b1;
          state_d = SCROLL_RD;
        end
      end

      SCROLL_FILL: begin
        we_d    = 1'b1;
        addr_d  = cnt;
        wdata_d = FILL;
        if (cnt == LAST_CELL) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = CLEAR;
      end
    endcase
  end

  always_ff @(posedge vclk) begin
    if (!rst_n) begin
      state     <= CLEAR;
      cnt       <= '0;
      cur_col   <= '0;
      cur_row   <= '0;
      row_base  <= '0;
      byte_q    <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
      busy      <= 1'b1;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      cur_col   <= col_d;
      cur_row   <= row_d;
      row_base  <= row_base_d;
      byte_q    <= byte_d;
      ram_addr  <= addr_d;
      ram_wdata <= wdata_d;
      ram_we    <= we_d;
      busy      <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_vga_text_console.sv
// Bench for vga_text_console: behavioural video RAM, write scoreboard fed by
// the stimulus tasks, inline cursor/handshake checks per scenario.
module tb_vga_text_console;
  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam int AW   = 12;
  localparam int N    = COLS*ROWS;

  logic          vclk = 1'b0;
  logic          rst_n;
  logic [7:0]    char_in;
  logic          char_valid;
  logic          char_ready;
  logic          cls;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata;
  logic          ram_we;
  logic [7:0]    ram_rdata;
  logic [6:0]    cur_col;
  logic [4:0]    cur_row;
  logic          busy;

  always #5 vclk = ~vclk;

  vga_text_console #(.COLS(COLS), .ROWS(ROWS), .AW(AW), .FILL(8'h20)) dut (
    .vclk(vclk), .rst_n(rst_n), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .cls(cls), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .cur_col(cur_col), .cur_row(cur_row), .busy(busy)
  );

  // Video RAM: read data follows ram_addr, writes land on the clock edge.
  logic [7:0] mem [0:(1<<AW)-1];
  logic       preload = 1'b0;
  assign ram_rdata = mem[ram_addr];
  always @(posedge vclk) begin
    if (preload) begin
      for (int a = 0; a < (1<<AW); a++) mem[a] <= 8'(a);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
  end

  int         vectors = 0;
  int         miscompares = 0;
  logic       mon_en = 1'b1;
  logic [19:0] exp_q [$];
  logic [19:0] exp_w;

  always @(negedge vclk) begin
    if (mon_en && ram_we) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write addr=%0d data=%h", ram_addr, ram_wdata);
      end else begin
        exp_w = exp_q.pop_front();
        if ({ram_addr, ram_wdata} !== exp_w) begin
          miscompares++;
          $display("FAIL ram_write got addr=%0d data=%h expected addr=%0d data=%h",
                   ram_addr, ram_wdata, exp_w[19:8], exp_w[7:0]);
        end
      end
    end
  end

  task automatic push_fill(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) exp_q.push_back({12'(a), 8'h20});
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge vclk);
    while ((busy || exp_q.size() != 0) && n < 20000) begin
      @(negedge vclk);
      n++;
    end
    if (n >= 20000) begin
      vectors++; miscompares++;
      $display("FAIL %s timeout busy=%0b pending=%0d", tag, busy, exp_q.size());
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (!char_ready && n < 20000) begin
      @(negedge vclk);
      n++;
    end
    if (n >= 20000) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout byte=%h", b);
    end
    char_in = b;
    char_valid = 1'b1;
    @(posedge vclk);
    @(negedge vclk);
    char_valid = 1'b0;
  endtask

  task automatic test_reset();
    int n = 0;
    rst_n = 1'b0; cls = 1'b0; char_valid = 1'b0; char_in = 8'h00;
    repeat (3) @(posedge vclk);
    @(negedge vclk);
    vectors++;
    if ({ram_we, ram_addr, ram_wdata, cur_col, cur_row, char_ready, busy} !==
        {1'b0, 12'd0, 8'd0, 7'd0, 5'd0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_state we=%0b addr=%0d wdata=%h col=%0d row=%0d rdy=%0b busy=%0b required 0 0 00 0 0 0 1",
               ram_we, ram_addr, ram_wdata, cur_col, cur_row, char_ready, busy);
    end
    push_fill(0, N-1);
    rst_n = 1'b1;
    while (!ram_we && n < 10) begin @(negedge vclk); n++; end
    n = 0;
    while (ram_we && n < 3000) begin @(negedge vclk); n++; end
    vectors++;
    if (n !== N) begin
      miscompares++;
      $display("FAIL clear_length got %0d required %0d", n, N);
    end
    vectors++;
    if ({char_ready, busy, cur_col, cur_row} !== {1'b1, 1'b0, 7'd0, 5'd0}) begin
      miscompares++;
      $display("FAIL after_clear rdy=%0b busy=%0b col=%0d row=%0d required 1 0 0 0",
               char_ready, busy, cur_col, cur_row);
    end
  endtask

  task automatic test_char();
    exp_q.push_back({12'd0, 8'h41});
    send_byte(8'h41);
    vectors++;
    if (char_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL exec_ready got %0b required 0", char_ready);
    end
    @(negedge vclk);
    vectors++;
    if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 12'd0, 8'h41}) begin
      miscompares++;
      $display("FAIL char_write_latency we=%0b addr=%0d data=%h required 1 0 41",
               ram_we, ram_addr, ram_wdata);
    end
    vectors++;
    if ({cur_col, char_ready} !== {7'd1, 1'b1}) begin
      miscompares++;
      $display("FAIL char_cursor col=%0d rdy=%0b required 1 1", cur_col, char_ready);
    end
    wait_idle("char");
  endtask

  task automatic test_wrap();
    push_fill(0, N-1);
    send_byte(8'h0C);
    wait_idle("ff_clear");
    vectors++;
    if ({cur_col, cur_row} !== {7'd0, 5'd0}) begin
      miscompares++;
      $display("FAIL ff_cursor col=%0d row=%0d required 0 0", cur_col, cur_row);
    end
    for (int i = 0; i < COLS; i++) begin
      exp_q.push_back({12'(i), 8'h42});
      send_byte(8'h42);
    end
    wait_idle("wrap");
    vectors++;
    if ({cur_col, cur_row} !== {7'd0, 5'd1}) begin
      miscompares++;
      $display("FAIL wrap_cursor col=%0d row=%0d required 0 1", cur_col, cur_row);
    end
    send_byte(8'h0A);
    wait_idle("lf");
    vectors++;
    if ({cur_col, cur_row} !== {7'd0, 5'd2}) begin
      miscompares++;
      $display("FAIL lf_cursor col=%0d row=%0d required 0 2", cur_col, cur_row);
    end
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({12'(160+i), 8'h41});
      send_byte(8'h41);
    end
    send_byte(8'h0D);
    wait_idle("cr");
    vectors++;
    if ({cur_col, cur_row} !== {7'd0, 5'd2}) begin
      miscompares++;
      $display("FAIL cr_cursor col=%0d row=%0d required 0 2", cur_col, cur_row);
    end
  endtask

  task automatic test_bs();
    send_byte(8'h08);
    wait_idle("bs0");
    vectors++;
    if ({cur_col, cur_row} !== {7'd0, 5'd2}) begin
      miscompares++;
      $display("FAIL bs_col0 col=%0d row=%0d required 0 2", cur_col, cur_row);
    end
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({12'(160+i), 8'h61});
      send_byte(8'h61);
    end
    send_byte(8'h08);
    wait_idle("bs5");
    vectors++;
    if ({cur_col, cur_row} !== {7'd4, 5'd2}) begin
      miscompares++;
      $display("FAIL bs_col5 col=%0d row=%0d required 4 2", cur_col, cur_row);
    end
    send_byte(8'h07);
    wait_idle("bel");
    vectors++;
    if ({cur_col, cur_row} !== {7'd4, 5'd2}) begin
      miscompares++;
      $display("FAIL ignored_ctrl col=%0d row=%0d required 4 2", cur_col, cur_row);
    end
  endtask

  // From a fresh screen, leave the cursor at (79,29) without scrolling.
  task automatic goto_last_cell();
    push_fill(0, N-1);
    send_byte(8'h0C);
    wait_idle("pre_clear");
    for (int i = 0; i < ROWS-1; i++) send_byte(8'h0A);
    for (int i = 0; i < COLS-1; i++) begin
      exp_q.push_back({12'(COLS*(ROWS-1)+i), 8'h44});
      send_byte(8'h44);
    end
    wait_idle("to_last");
    vectors++;
    if ({cur_col, cur_row} !== {7'd79, 5'd29}) begin
      miscompares++;
      $display("FAIL last_cell_cursor col=%0d row=%0d required 79 29", cur_col, cur_row);
    end
  endtask

  task automatic test_scroll();
    int bc = 0;
    int errs = 0;
    logic [11:0] src;
    logic [7:0]  d;
    goto_last_cell();
    preload = 1'b1;
    @(posedge vclk);
    @(negedge vclk);
    preload = 1'b0;
    exp_q.push_back({12'(N-1), 8'h43});
    for (int i = 0; i < COLS*(ROWS-1); i++) begin
      src = 12'(i + COLS);
      d = (src == 12'(N-1)) ? 8'h43 : src[7:0];
      exp_q.push_back({12'(i), d});
    end
    push_fill(COLS*(ROWS-1), N-1);
    send_byte(8'h43);
    @(negedge vclk);
    while (busy && bc < 6000) begin
      bc++;
      @(negedge vclk);
    end
    vectors++;
    if (bc !== 4720) begin
      miscompares++;
      $display("FAIL scroll_busy_cycles got %0d required 4720", bc);
    end
    wait_idle("scroll");
    vectors++;
    if ({cur_col, cur_row} !== {7'd0, 5'd29}) begin
      miscompares++;
      $display("FAIL scroll_cursor col=%0d row=%0d required 0 29", cur_col, cur_row);
    end
    for (int a = 0; a < N; a++) begin
      src = 12'(a + COLS);
      if (a >= COLS*(ROWS-1)) d = 8'h20;
      else d = (src == 12'(N-1)) ? 8'h43 : src[7:0];
      if (mem[a] !== d) errs++;
    end
    vectors++;
    if (errs != 0) begin
      miscompares++;
      $display("FAIL scroll_ram_image bad_cells=%0d required 0", errs);
    end
  endtask

  task automatic test_cls();
    cls = 1'b1;
    char_in = 8'h45;
    char_valid = 1'b1;
    #1;
    vectors++;
    if (char_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL cls_ready got %0b required 0", char_ready);
    end
    push_fill(0, N-1);
    @(posedge vclk);
    @(negedge vclk);
    cls = 1'b0;
    char_valid = 1'b0;
    wait_idle("cls");
    vectors++;
    if ({cur_col, cur_row} !== {7'd0, 5'd0}) begin
      miscompares++;
      $display("FAIL cls_cursor col=%0d row=%0d required 0 0", cur_col, cur_row);
    end
  endtask

  task automatic test_reset_mid_scroll();
    int n = 0;
    goto_last_cell();
    mon_en = 1'b0;
    send_byte(8'h46);
    repeat (100) @(negedge vclk);
    rst_n = 1'b0;
    @(negedge vclk);
    vectors++;
    if ({ram_we, busy} !== {1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_mid_scroll we=%0b busy=%0b required 0 1", ram_we, busy);
    end
    exp_q.delete();
    push_fill(0, N-1);
    mon_en = 1'b1;
    rst_n = 1'b1;
    @(negedge vclk);
    while (!ram_we && n < 10) begin @(negedge vclk); n++; end
    vectors++;
    if ({ram_we, ram_addr} !== {1'b1, 12'd0}) begin
      miscompares++;
      $display("FAIL restart_clear we=%0b addr=%0d required 1 0", ram_we, ram_addr);
    end
    wait_idle("restart");
    vectors++;
    if ({cur_col, cur_row, busy} !== {7'd0, 5'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL restart_cursor col=%0d row=%0d busy=%0b required 0 0 0",
               cur_col, cur_row, busy);
    end
  endtask

  initial begin
    test_reset();
    test_char();
    test_wrap();
    test_bs();
    test_scroll();
    test_cls();
    test_reset_mid_scroll();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_writes got %0d required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
